// File: rtl/rc5_key_schedule_ctrl_if.sv
// Handshake and S/L RAM port bundle between the RC5 key-schedule controller,
// the L-array loader and the two key RAMs.
interface rc5_key_schedule_ctrl_if #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16
);
    localparam int U   = W / 8;
    localparam int C   = (B / U > 1) ? B / U : 1;
    localparam int T   = 2 * (R + 1);
    localparam int LAW = (C > 1) ? $clog2(C) : 1;
    localparam int SAW = $clog2(T);

    logic           start;
    logic           busy;
    logic           done;
    logic           lop_start;
    logic           lop_done;
    logic           l_sel;
    logic [LAW-1:0] l_addr;
    logic [W-1:0]   l_rdata;
    logic [W-1:0]   l_wdata;
    logic           l_we;
    logic [SAW-1:0] s_addr;
    logic [W-1:0]   s_rdata;
    logic [W-1:0]   s_wdata;
    logic           s_we;

    modport master (
        input  start, lop_done, l_rdata, s_rdata,
        output busy, done, lop_start, l_sel, l_addr, l_wdata, l_we,
               s_addr, s_wdata, s_we
    );

    modport slave (
        output start, lop_done, l_rdata, s_rdata,
        input  busy, done, lop_start, l_sel, l_addr, l_wdata, l_we,
               s_addr, s_wdata, s_we
    );
endinterface

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key expansion sequencer: L load, S init with P/Q progression, then the
// 3*max(T,C) mixing loop. Every output comes straight from a register.
module rc5_key_schedule_ctrl #(
    parameter int         W   = 32,
    parameter int         R   = 12,
    parameter int         B   = 16,
    parameter logic [W-1:0] P_W = 32'hB7E15163,
    parameter logic [W-1:0] Q_W = 32'h9E3779B9
) (
    input  logic                    clk,
    input  logic                    rst,
    rc5_key_schedule_ctrl_if.master bus
);
    localparam int U   = W / 8;
    localparam int C   = (B / U > 1) ? B / U : 1;
    localparam int T   = 2 * (R + 1);
    localparam int N   = 3 * ((T > C) ? T : C);
    localparam int LG  = $clog2(W);
    localparam int LAW = (C > 1) ? $clog2(C) : 1;
    localparam int SAW = $clog2(T);
    localparam int KW  = $clog2(N);

    localparam logic [SAW-1:0] T_LAST = SAW'(T - 1);
    localparam logic [LAW-1:0] C_LAST = LAW'(C - 1);
    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_L, S_INIT_S, S_MIX_RD, S_MIX_WAIT, S_MIX_S, S_MIX_L, S_DONE
    } state_e;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LG-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, lw_q, lw_d, acc_q, acc_d;
    logic [SAW-1:0] i_q, i_d;
    logic [LAW-1:0] j_q, j_d;
    logic [KW-1:0]  k_q, k_d;

    logic           busy_q, busy_d, done_q, done_d, lop_start_q, lop_start_d;
    logic           l_sel_q, l_sel_d, l_we_q, l_we_d, s_we_q, s_we_d;
    logic [LAW-1:0] l_addr_q, l_addr_d;
    logic [SAW-1:0] s_addr_q, s_addr_d;
    logic [W-1:0]   l_wdata_q, l_wdata_d, s_wdata_q, s_wdata_d;

    logic [W-1:0]   ab_sum, a_sum, b_sum;
    assign ab_sum = a_q + b_q;
    assign a_sum  = bus.s_rdata + ab_sum;
    assign b_sum  = lw_q + ab_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            lw_q        <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lop_start_q <= 1'b0;
            l_sel_q     <= 1'b0;
            l_we_q      <= 1'b0;
            s_we_q      <= 1'b0;
            l_addr_q    <= '0;
            s_addr_q    <= '0;
            l_wdata_q   <= '0;
            s_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            lw_q        <= lw_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lop_start_q <= lop_start_d;
            l_sel_q     <= l_sel_d;
            l_we_q      <= l_we_d;
            s_we_q      <= s_we_d;
            l_addr_q    <= l_addr_d;
            s_addr_q    <= s_addr_d;
            l_wdata_q   <= l_wdata_d;
            s_wdata_q   <= s_wdata_d;
        end
    end

    // Read data is sampled in MIX_WAIT so the S/L writes land in MIX_S/MIX_L
    // through the output registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lw_d    = lw_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE:     if (bus.start) state_d = S_LOAD_L;
            S_LOAD_L: begin
                if (bus.lop_done) begin
                    state_d = S_INIT_S;
                    i_d     = '0;
                    acc_d   = P_W;
                end
            end
            S_INIT_S: begin
                if (i_q == T_LAST) begin
                    state_d = S_MIX_RD;
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    i_d   = i_q + 1'b1;
                    acc_d = acc_q + Q_W;
                end
            end
            S_MIX_RD:   state_d = S_MIX_WAIT;
            S_MIX_WAIT: begin
                state_d = S_MIX_S;
                a_d     = rotl(a_sum, LG'(3));
                lw_d    = bus.l_rdata;
            end
            S_MIX_S: begin
                state_d = S_MIX_L;
                b_d     = rotl(b_sum, ab_sum[LG-1:0]);
            end
            S_MIX_L: begin
                i_d     = (i_q == T_LAST) ? '0 : i_q + 1'b1;
                j_d     = (j_q == C_LAST) ? '0 : j_q + 1'b1;
                k_d     = k_q + 1'b1;
                state_d = (k_q == K_LAST) ? S_DONE : S_MIX_RD;
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    logic mix_d;
    always_comb begin
        mix_d       = (state_d == S_MIX_RD) || (state_d == S_MIX_WAIT) ||
                      (state_d == S_MIX_S)  || (state_d == S_MIX_L);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        lop_start_d = (state_q == S_IDLE) && (state_d == S_LOAD_L);
        l_sel_d     = (state_d == S_INIT_S) || mix_d;
        s_we_d      = (state_d == S_INIT_S) || (state_d == S_MIX_S);
        l_we_d      = (state_d == S_MIX_L);
        s_addr_d    = ((state_d == S_INIT_S) || mix_d) ? i_d : '0;
        l_addr_d    = mix_d ? j_d : '0;
        s_wdata_d   = '0;
        if (state_d == S_INIT_S)     s_wdata_d = acc_d;
        else if (state_d == S_MIX_S) s_wdata_d = a_d;
        l_wdata_d   = (state_d == S_MIX_L) ? b_d : '0;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lop_start = lop_start_q;
    assign bus.l_sel     = l_sel_q;
    assign bus.l_we      = l_we_q;
    assign bus.s_we      = s_we_q;
    assign bus.l_addr    = l_addr_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.l_wdata   = l_wdata_q;
    assign bus.s_wdata   = s_wdata_q;
endmodule

// File: doc/rc5_key_schedule_ctrl.md
Name: rc5_key_schedule_ctrl

Overview:
- Sequences the complete RC5 key expansion around the existing L-array loader and the S/L RAMs.
- Phase 1 triggers the L loader and waits for it to finish, so L holds the key bytes packed into W-bit words.
- Phase 2 fills the S table with the magic-constant progression.
- Phase 3 runs the 3*max(T,C) mixing loop, then signals completion to the cipher core.
- Owns the L RAM port mux, so the loader and the mixer never collide.

Parameters:
- W, 32, word width in bits; only 32 is supported.
- R, 12, number of rounds.
- B, 16, key length in bytes.
- P_W, 32'hB7E15163, magic constant P.
- Q_W, 32'h9E3779B9, magic constant Q.
- Derived constants, all localparam:
  - U = W/8
  - C = max(1, B/U)
  - T = 2*(R+1)
  - N = 3*max(T,C)
  - LG = $clog2(W)

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a key expansion. Sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the schedule is complete.
- lop_start, out, 1: one-cycle pulse that launches the L loader.
- lop_done, in, 1: level from the L loader; high once L is fully written.
- l_sel, out, 1: L RAM owner. 1 = this block, 0 = loader.
- l_addr, out, $clog2(C): L RAM address.
- l_rdata, in, W: L RAM read data, 1-cycle synchronous read.
- l_wdata, out, W: L RAM write data.
- l_we, out, 1: L RAM write enable.
- s_addr, out, $clog2(T): S RAM address.
- s_rdata, in, W: S RAM read data, 1-cycle synchronous read.
- s_wdata, out, W: S RAM write data.
- s_we, out, 1: S RAM write enable.

Behaviour:
- Reset: state=IDLE and all outputs 0, including busy, done, lop_start, l_sel, l_we, s_we, l_addr, s_addr, l_wdata and s_wdata. Internal A, B, i, j, k and the init accumulator are also cleared.
- Reset mid-operation aborts at the next edge with the same values. Partial RAM contents are don't-care.
- All outputs are registered.
- States:
  - IDLE: when start=1, go to LOAD_L and pulse lop_start for exactly one cycle. start while busy is ignored.
  - LOAD_L: l_sel=0. Wait for lop_done=1, then go to INIT_S.
  - INIT_S: l_sel=1. One S write per cycle for idx 0..T-1: s_addr=idx, s_wdata=P_W+idx*Q_W mod 2^W. The value comes from a running accumulator; no multiplier is used. After idx=T-1, clear A, B, i, j and k, then go to MIX_RD.
  - MIX_RD: drive s_addr=i and l_addr=j with writes disabled.
  - MIX_WAIT: 1-cycle RAM latency.
  - MIX_S: compute A'=rotl(s_rdata+A+B, 3). Write s_we=1, s_addr=i, s_wdata=A'. Latch A=A' and the sampled L word.
  - MIX_L: compute B'=rotl(Lword+A+B, (A+B) mod W), where A is already A'. Write l_we=1, l_addr=j, l_wdata=B'. Latch B=B'. Update i=(i==T-1)?0:i+1, j=(j==C-1)?0:j+1, k=k+1. If k==N-1, go to DONE; else go to MIX_RD.
  - DONE: done=1 for one cycle, l_sel returns to 0, then IDLE.
- Arithmetic: all additions are mod 2^W. The rotate amount is the low LG bits of the sum; an amount of 0 leaves the value unchanged.
- Timing: 4 cycles per mix iteration. Start to done = 1 + loader time + T + 4N + 1 cycles. With the defaults this is 1 + loader + 26 + 312 + 1.
- i and j wrap independently. When C divides T the pattern is still correct.
- s_we and l_we are never both high in the same cycle.
- l_we is only ever driven when l_sel=1.
- A new start is accepted only after returning to IDLE, so back-to-back requests cost at least 1 idle cycle.

Test Plan:
- Reset behaviour: assert rst for 2 cycles, then release with start=0 → all outputs 0 and busy=0 indefinitely. With start=1 → lop_start high for exactly 1 cycle and busy=1; no RAM writes until lop_done rises.
- Init phase: run with defaults and hold lop_done=1 after 5 cycles → 26 consecutive s_we cycles with S[0]=B7E15163, S[1]=5618CB1C, S[25]=2B4C3474, and l_we=0 throughout.
- First mix iteration with an all-zero key (L=0): the first S write is S[0]=BF0A8B1D and the first L write is L[0]=B7E15163. The second iteration reads S[1] and L[1].
- Full schedule against a golden model for key 00..0F (B=16) → final S[0..25] and L[0..3] match the model. Exactly 78 S writes and 78 L writes occur, done pulses once, and the loop takes 312 cycles.
- Apply rst in MIX_L at k=40 → IDLE next cycle with busy=0 and l_sel=0. A fresh start reruns the full schedule and produces the same golden result.
- Protocol checks: pulse start during INIT_S and during MIX → ignored, no second lop_start. Assert ports never show s_we and l_we high together, and never show l_we without l_sel.
